// File: rtl/alu_pkg.sv
// ALU stage shared definitions: opcodes, FSM encoding, flag bit
// positions and the opcode writing/illegal classifier. Build macro: ALU_SHIFT_EN.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_CMP  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_SHR  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam int FLAG_C = 3;
    localparam int FLAG_O = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    // Returns {writes_regfile, illegal}.
    function automatic logic [1:0] op_class(input logic [2:0] op);
        logic [1:0] cls;
        cls = 2'b01;
        case (op)
            OP_ADD, OP_SUB, OP_PASS: cls = 2'b10;
            OP_CMP:                  cls = 2'b00;
`ifdef ALU_SHIFT_EN
            OP_SHL, OP_SHR:          cls = 2'b10;
`endif
            default:                 cls = 2'b01;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (op, a, b) -> (r, C, O, Z, N).
// Ports: i_op, i_a, i_b in; o_r, o_c, o_o, o_z, o_n out. Macro: ALU_SHIFT_EN.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_r,
    output logic             o_c,
    output logic             o_o,
    output logic             o_z,
    output logic             o_n
);

    localparam int M = WIDTH - 1;

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_dif;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    // a + ~b + 1: carry out is the inverted borrow
    assign w_dif = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        o_r = '0;
        o_c = 1'b0;
        o_o = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_r = w_sum[M:0];
                o_c = w_sum[WIDTH];
                o_o = (i_a[M] == i_b[M]) && (w_sum[M] != i_a[M]);
            end
            OP_SUB, OP_CMP: begin
                o_r = w_dif[M:0];
                o_c = w_dif[WIDTH];
                o_o = (i_a[M] != i_b[M]) && (w_dif[M] != i_a[M]);
            end
`ifdef ALU_SHIFT_EN
            OP_SHL: begin
                o_r = {i_a[M-1:0], 1'b0};
                o_c = i_a[M];
                o_o = i_a[M] ^ i_a[M-1];
            end
            OP_SHR: begin
                o_r = {1'b0, i_a[M:1]};
                o_c = i_a[0];
            end
`endif
            OP_PASS: begin
                o_r = i_b;
            end
            default: begin
                o_r = '0;
            end
        endcase
        o_z = (o_r == '0);
        o_n = o_r[M];
    end

endmodule

// File: rtl/alu_flag_stage.sv
// Multicycle ALU stage: IDLE/EXEC/WB FSM, operand latches, result and
// {C,O,Z,N} flag registers, register-file write-back decode. Macro: ALU_SHIFT_EN.
// Ports: clock, reset(async low), run, start, op, op_a, op_b, dest in;
// busy, done, wr_en, wr_sel, result, flags, illegal out.
module alu_flag_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       dest,
    output logic             busy,
    output logic             done,
    output logic             wr_en,
    output logic [1:0]       wr_sel,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal
);

    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_dest;
    logic             r_wr;
    logic             r_ill;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic [3:0]       r_pflags;

    logic [WIDTH-1:0] w_r;
    logic             w_c;
    logic             w_o;
    logic             w_z;
    logic             w_n;
    logic [3:0]       w_flags;
    logic [1:0]       w_cls;
    logic             w_wb;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .o_r  (w_r),
        .o_c  (w_c),
        .o_o  (w_o),
        .o_z  (w_z),
        .o_n  (w_n)
    );

    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_C] = w_c;
        w_flags[FLAG_O] = w_o;
        w_flags[FLAG_Z] = w_z;
        w_flags[FLAG_N] = w_n;
    end

    // Classify at latch time so write-back decode uses only registers
    assign w_cls = op_class(op);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_dest   <= '0;
            r_wr     <= 1'b0;
            r_ill    <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
            r_pflags <= '0;
        end else if (run) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_dest  <= dest;
                        r_wr    <= w_cls[1];
                        r_ill   <= w_cls[0];
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // CMP and illegal ops leave the write data untouched
                    if (r_wr) begin
                        r_result <= w_r;
                    end
                    r_pflags <= w_flags;
                    r_state  <= ST_WB;
                end
                ST_WB: begin
                    if (!r_ill) begin
                        r_flags <= r_pflags;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_wb    = (r_state == ST_WB);
    assign busy    = (r_state == ST_EXEC) || w_wb;
    assign done    = w_wb & run;
    assign wr_en   = w_wb & r_wr & run;
    assign illegal = w_wb & r_ill & run;
    assign wr_sel  = r_dest;
    assign result  = r_result;
    assign flags   = r_flags;

endmodule
